// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encodings, FSM state codes and default widths
//               for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = 6;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sign_fix
// Description : Two's-complement correction of a magnitude result: the full
//               double-width product, or quotient/remainder independently.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic                 is_mul,
    input  logic                 neg_hi,
    input  logic                 neg_lo,
    input  logic [2*WIDTH-1:0]   val,
    output logic [WIDTH-1:0]     hi_res,
    output logic [WIDTH-1:0]     lo_res
);

    logic [2*WIDTH-1:0] w_full_neg;
    logic [WIDTH-1:0]   w_hi_neg;
    logic [WIDTH-1:0]   w_lo_neg;

    assign w_full_neg = -val;
    assign w_hi_neg   = -val[2*WIDTH-1:WIDTH];
    assign w_lo_neg   = -val[WIDTH-1:0];

    always_comb begin
        hi_res = val[2*WIDTH-1:WIDTH];
        lo_res = val[WIDTH-1:0];
        if (is_mul) begin
            if (neg_lo) begin
                hi_res = w_full_neg[2*WIDTH-1:WIDTH];
                lo_res = w_full_neg[WIDTH-1:0];
            end
        end else begin
            if (neg_hi) hi_res = w_hi_neg;
            if (neg_lo) lo_res = w_lo_neg;
        end
    end

endmodule : mdu_sign_fix
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative shift-add multiplier / restoring divider with
//               architectural HI/LO. Optional macro MDU_EARLY_OUT_EN lets
//               multiplies finish once the remaining multiplier bits are zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = MDU_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_mul;
    logic               r_neg_hi;
    logic               r_neg_lo;
    logic               r_dbz_pend;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0]   w_mplr_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Unsigned ops have op[0]=1; signed ops operate on magnitudes.
    assign w_is_div = op[1];
    assign w_a_neg  = ~op[0] & src_a[WIDTH-1];
    assign w_b_neg  = ~op[0] & src_b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -src_a : src_a;
    assign w_abs_b  = w_b_neg ? -src_b : src_b;

    assign w_mul_acc   = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplr_next = r_mplr >> 1;

    // r_acc holds {remainder, dividend/quotient}; r_mplr holds the divisor.
    assign w_diff    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mplr};
    assign w_div_acc = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

`ifdef MDU_EARLY_OUT_EN
    assign w_last = (r_cnt == CNT_W'(WIDTH-1)) || (r_is_mul && (w_mplr_next == '0));
`else
    assign w_last = (r_cnt == CNT_W'(WIDTH-1));
`endif

    mdu_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .is_mul (r_is_mul),
        .neg_hi (r_neg_hi),
        .neg_lo (r_neg_lo),
        .val    (r_acc),
        .hi_res (w_fix_hi),
        .lo_res (w_fix_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_mul   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplr     <= '0;
            r_a_raw    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc      <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : '0;
                        r_mcand    <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplr     <= w_abs_b;
                        r_is_mul   <= ~w_is_div;
                        r_neg_lo   <= w_a_neg ^ w_b_neg;
                        r_neg_hi   <= w_is_div ? w_a_neg : (w_a_neg ^ w_b_neg);
                        r_a_raw    <= src_a;
                        r_dbz_pend <= w_is_div && (src_b == '0);
                        r_div_zero <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= CALC;
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_is_mul) begin
                        r_acc   <= w_mul_acc;
                        r_mcand <= r_mcand << 1;
                        r_mplr  <= w_mplr_next;
                    end else begin
                        r_acc <= w_div_acc;
                    end
                    if (w_last) r_state <= FIX;
                end
                FIX: begin
                    if (r_dbz_pend) begin
                        r_hi       <= r_a_raw;
                        r_lo       <= '1;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_hi <= w_fix_hi;
                        r_lo <= w_fix_lo;
                    end
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_div_zero;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed plus randomized bench for mul_div_unit with an
//               arithmetic reference model of HI/LO, latency and div-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic        m_dbz  = 1'b0;

    mul_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output logic ed, output int lat);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] ua, ub, p;
        logic [31:0] m;
        int k;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ed = 1'b0;
        lat = 33;
        case (o)
            2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (b == 0) begin eh = a; el = '1; ed = 1'b1; end
                else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
            end
            default: begin
                if (b == 0) begin eh = a; el = '1; ed = 1'b1; end
                else begin p = ua / ub; eh = 32'(ua % ub); el = p[31:0]; end
            end
        endcase
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            m = (o == 2'b00 && b[31]) ? -b : b;
            k = 1;
            while (k < 32 && (m >> k) != 0) k++;
            lat = k + 1;
        end
`endif
    endtask

    // Called #1 after a posedge with the unit idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input string tag);
        logic [31:0] eh, el;
        logic ed;
        int lat, cyc;
        model(o, a, b, eh, el, ed, lat);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        src_a = $urandom; src_b = $urandom;
        check({tag, "_busy_start"}, busy, 1'b1);
        check({tag, "_dbz_clear"}, div_by_zero, 1'b0);
        cyc = 0;
        while (!done && cyc < 40) begin
            if (inject) begin
                start = (cyc == 5);
                hi_we = (cyc == 5);
                op    = (cyc == 5) ? 2'b11 : o;
                wdata = 32'h1234;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; hi_we = 1'b0;
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_dbz"}, div_by_zero, ed);
        m_hi = eh; m_lo = el; m_dbz = ed;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic idle_write(input logic hw, input logic lw, input logic [31:0] d, input string tag);
        hi_we = hw; lo_we = lw; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        check({tag, "_hi"}, hi, m_hi);
        check({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int pulses;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 0, "mult_neg3x5");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_max");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, "div_neg7by2");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        run_op(2'b11, 32'd100, 32'd0, 0, "divu_zero");
        run_op(2'b01, 32'd7, 32'd9, 0, "multu_after_dbz");
        run_op(2'b00, 32'h00012345, 32'hFFFF0003, 1, "mult_inject");
        run_op(2'b00, 32'hDEADBEEF, 32'd1, 0, "mult_by1");
        run_op(2'b00, 32'h80000000, 32'd0, 0, "mult_by0");
        idle_write(1'b0, 1'b1, 32'hABCD, "mtlo");
        idle_write(1'b1, 1'b1, 32'h5A5A_0F0F, "mthi_mtlo");

        // Synchronous reset mid-divide discards the operation.
        start = 1'b1; op = 2'b10; src_a = 32'h0001_0000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", busy, 1'b0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        check("midrst_no_done", pulses, 0);
        run_op(2'b11, 32'd9, 32'd4, 0, "divu_9by4");

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(0, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 0, "rand_op");
            if (i % 4 == 0)
                idle_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "rand_wr");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mul_div_unit
`default_nettype wire
